// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the bus selector family.
//               - Mode encodings for the selector (direct select / round-robin)
//               - Index wrap helper used to advance the round-robin pointer
// Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

  localparam logic MODE_SEL = 1'b0;  // direct select by index
  localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

  // Next index after idx in a ring of n entries (n-1 wraps to 0).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant search. Picks the first set
//               request at or above i_ptr, wrapping N-1 -> 0.
// Ports       : i_req       [N-1:0]     request vector
//               i_ptr       [SELW-1:0]  search start (always < N)
//               o_gnt_valid             a request was found
//               o_gnt_idx   [SELW-1:0]  index of the granted request
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 9,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_gnt_valid,
  output logic [SELW-1:0] o_gnt_idx
);

  logic [SELW-1:0] w_idx;

  // Scan offsets from farthest to nearest so the closest request to i_ptr
  // is the last one written and therefore wins.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = SELW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_sel_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_sel_rr
// Description : Registered N-to-1 bus selector with valid/ready on every
//               channel and on the output. Direct-select or round-robin
//               grant, one-entry output register, full throughput.
// Ports       : clk, rst_n            clock, async active-low reset
//               i_mode                0 = direct select, 1 = round-robin
//               i_sel     [SELW-1:0]  channel index for direct select
//               i_in_data [N*WIDTH]   flat input bus, channel i at [i*WIDTH +: WIDTH]
//               i_in_valid[N-1:0]     per-channel valid
//               o_in_ready[N-1:0]     per-channel ready (one-hot or zero)
//               o_out_data[WIDTH-1:0] registered selected word
//               o_out_valid           output register holds a word
//               i_out_ready           consumer accepts the word
//               o_out_chan[SELW-1:0]  source channel of o_out_data
// Revision    : 1.0  initial release
// ============================================================================
module bus_sel_rr
  import bus_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 9,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_mode,
  input  logic [SELW-1:0]      i_sel,
  input  logic [N*WIDTH-1:0]   i_in_data,
  input  logic [N-1:0]         i_in_valid,
  output logic [N-1:0]         o_in_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SELW-1:0]      o_out_chan
);

  localparam int SELN = 1 << SELW;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_chan;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic [SELN-1:0]  w_valid_pad;
  logic             w_sel_ok;
  logic             w_arb_valid;
  logic [SELW-1:0]  w_arb_idx;
  logic             w_gnt_valid;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_hs;
  logic [WIDTH-1:0] w_chan_data [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_chan_data[g] = i_in_data[g*WIDTH +: WIDTH];
  end

  assign w_load_en = !r_out_valid || i_out_ready;

  // Pad valid to the full sel range so out-of-range indices read 0 and the
  // explicit range check keeps them from ever granting.
  assign w_valid_pad = SELN'(i_in_valid);
  assign w_sel_ok    = (int'(i_sel) < N) && w_valid_pad[i_sel];

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .i_req       (i_in_valid),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_arb_valid),
    .o_gnt_idx   (w_arb_idx)
  );

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    if (i_mode == MODE_RR) begin
      w_gnt_valid = w_arb_valid;
      w_gnt_idx   = w_arb_idx;
    end else if (w_sel_ok) begin
      w_gnt_valid = 1'b1;
      w_gnt_idx   = i_sel;
    end
  end

  // rst_n gates the handshake so no channel sees ready while in reset,
  // even though the empty output register would otherwise accept a word.
  assign w_hs = rst_n && w_load_en && w_gnt_valid;

  for (genvar g = 0; g < N; g++) begin : g_ready
    assign o_in_ready[g] = w_hs && (w_gnt_idx == SELW'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_hs) begin
      r_out_data  <= w_chan_data[w_gnt_idx];
      r_out_chan  <= w_gnt_idx;
      r_out_valid <= 1'b1;
      if (i_mode == MODE_RR) begin
        r_ptr <= SELW'(wrap_inc(int'(w_gnt_idx), N));
      end
    end else if (i_out_ready) begin
      // Drained with nothing to replace it; data/chan keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_chan  = r_out_chan;

endmodule : bus_sel_rr
`default_nettype wire

// File: tb/tb_bus_sel_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_sel_rr
// Description : Self-checking bench for bus_sel_rr with a behavioural model
//               of the grant rules and the one-entry output register.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_sel_rr;

  localparam int WIDTH = 16;
  localparam int N     = 9;
  localparam int SELW  = 4;

  logic               clk;
  logic               rst_n;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;

  logic [WIDTH-1:0]   chd [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign in_data[gi*WIDTH +: WIDTH] = chd[gi];
  end

  bus_sel_rr #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_chan  (out_chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  int               m_ptr;

  logic [N-1:0]     exp_ready;
  logic [N-1:0]     obs_ready;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // Grant rule: direct select needs an in-range, valid sel; round-robin takes
  // the lowest valid index not below ptr, else the lowest valid index overall.
  function automatic void ref_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      for (int i = 0; i < N; i++)
        if (i == int'(sel) && in_valid[i]) begin ok = 1'b1; g = i; end
    end else begin
      for (int i = 0; i < N; i++)
        if (!ok && i >= m_ptr && in_valid[i]) begin ok = 1'b1; g = i; end
      for (int i = 0; i < N; i++)
        if (!ok && in_valid[i]) begin ok = 1'b1; g = i; end
    end
  endfunction

  // One clock: record expected/observed ready before the edge, advance the
  // model at the edge, return 1 time unit after it.
  task automatic tick();
    bit ok;
    int g;
    #1;
    ref_grant(ok, g);
    exp_ready = '0;
    if (rst_n && ok && (!m_valid || out_ready)) exp_ready = N'(1) << g;
    obs_ready = in_ready;
    @(posedge clk);
    if (rst_n) begin
      if (exp_ready != '0) begin
        m_data  = chd[g];
        m_chan  = g;
        m_valid = 1'b1;
        if (mode == 1'b1) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) chd[i] = 16'h1000 + 16'(i);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_default_data();
    model_reset();
    #3;
    n_tests++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_tests++;
    if (out_chan !== '0) begin n_fail++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL reset_hold_in_ready got=%h exp=0", in_ready); end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_chan !== 4'd0 || out_data !== 16'h1000) begin
      n_fail++;
      $display("FAIL reset_first_grant got v=%b ch=%0d d=%h exp v=1 ch=0 d=1000",
               out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_sel_sweep();
    mode      = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_default_data();
    for (int s = 0; s < N; s++) begin
      sel = SELW'(s);
      tick();
      n_tests++;
      if (obs_ready !== (N'(1) << s)) begin
        n_fail++; $display("FAIL sel_ready s=%0d got=%h exp=%h", s, obs_ready, N'(1) << s);
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h1000 + 16'(s) || out_chan !== SELW'(s)) begin
        n_fail++;
        $display("FAIL sel_out s=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 s, out_valid, out_data, out_chan, 16'h1000 + 16'(s), s);
      end
    end
    for (int s = N; s < 16; s++) begin
      sel = SELW'(s);
      tick();
      n_tests++;
      if (obs_ready !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sel_oor s=%0d got ready=%h v=%b exp ready=0 v=0", s, obs_ready, out_valid);
      end
    end
  endtask

  task automatic test_rr_fair();
    mode      = 1'b1;
    out_ready = 1'b1;
    set_default_data();
    in_valid  = 9'h100;      // channel 8 alone: moves the pointer to 0
    tick();
    n_tests++;
    if (out_chan !== 4'd8) begin n_fail++; $display("FAIL rr_prime got ch=%0d exp=8", out_chan); end
    in_valid = '1;
    for (int k = 0; k < 2 * N; k++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_chan !== SELW'(k % N) || out_data !== 16'h1000 + 16'(k % N)) begin
        n_fail++;
        $display("FAIL rr_fair k=%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d",
                 k, out_valid, out_chan, out_data, k % N);
      end
    end
  endtask

  task automatic test_rr_skip();
    int order [4] = '{7, 2, 7, 2};
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 9'b0_0000_0100;  // channel 2 alone: pointer becomes 3
    tick();
    n_tests++;
    if (out_chan !== 4'd2) begin n_fail++; $display("FAIL rr_skip_prime got ch=%0d exp=2", out_chan); end
    in_valid = 9'b0_1000_0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_chan !== SELW'(order[k])) begin
        n_fail++;
        $display("FAIL rr_skip k=%0d got v=%b ch=%0d exp v=1 ch=%0d", k, out_valid, out_chan, order[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int held_chan;
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    tick();                 // pointer 3 after the skip test: loads channel 3
    n_tests++;
    if (out_chan !== 4'd3) begin n_fail++; $display("FAIL bp_load got ch=%0d exp=3", out_chan); end
    held_chan = m_chan;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (obs_ready !== '0 || out_valid !== 1'b1 || out_data !== m_data || out_chan !== SELW'(m_chan)) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d got ready=%h v=%b d=%h ch=%0d exp ready=0 v=1 d=%h ch=%0d",
                 k, obs_ready, out_valid, out_data, out_chan, m_data, m_chan);
      end
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (obs_ready !== (N'(1) << ((held_chan + 1) % N)) || out_valid !== 1'b1 ||
        out_chan !== SELW'((held_chan + 1) % N)) begin
      n_fail++;
      $display("FAIL bp_release got ready=%h v=%b ch=%0d exp ch=%0d", obs_ready, out_valid,
               out_chan, (held_chan + 1) % N);
    end
  endtask

  task automatic test_midstream();
    int c;
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    set_default_data();
    tick();
    c = m_chan;
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 4'd5;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_chan !== SELW'(c) || out_data !== 16'h1000 + 16'(c)) begin
      n_fail++;
      $display("FAIL mid_switch got v=%b ch=%0d d=%h exp v=1 ch=%0d", out_valid, out_chan, out_data, c);
    end
    out_ready = 1'b1;
    tick();                 // held word leaves, channel 5 replaces it
    n_tests++;
    if (out_valid !== 1'b1 || out_chan !== 4'd5 || out_data !== 16'h1005) begin
      n_fail++;
      $display("FAIL mid_sel_load got v=%b ch=%0d d=%h exp v=1 ch=5 d=1005", out_valid, out_chan, out_data);
    end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;           // mid-cycle, no clock edge involved
    #1;
    model_reset();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset got v=%b d=%h ch=%0d ready=%h exp all 0",
               out_valid, out_data, out_chan, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_chan !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_ptr_cleared got v=%b ch=%0d exp v=1 ch=0", out_valid, out_chan);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, 15));
      in_valid  = N'($urandom);
      if ((k % 7) == 0) in_valid = '1;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) chd[i] = WIDTH'($urandom);
      tick();
      n_tests++;
      if (obs_ready !== exp_ready || out_valid !== m_valid || out_data !== m_data ||
          out_chan !== SELW'(m_chan)) begin
        n_fail++;
        $display("FAIL random k=%0d got ready=%h v=%b d=%h ch=%0d exp ready=%h v=%b d=%h ch=%0d",
                 k, obs_ready, out_valid, out_data, out_chan, exp_ready, m_valid, m_data, m_chan);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sel_sweep();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_bus_sel_rr
`default_nettype wire
